// File: rtl/clk_div_pkg.sv
// Shared state encoding and default sizing for the divided-clock sequencer.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 8;
  localparam int DIV_DEFAULT_DEF = 2;
  localparam int TICK_CNT_W      = 16;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter: div_out flips after div_reg+1 counting cycles; toggle strobes are combinational.
// Dropping run parks cnt and div_out at zero on the next edge; no backpressure.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div_reg,
  output logic             fall_toggle,
  output logic             rise_toggle,
  output logic             div_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_div_out;
  logic             w_hit;

  // Equality is enough: div_reg only changes on edges that also clear cnt.
  assign w_hit       = run && (r_cnt == div_reg);
  assign rise_toggle = w_hit && !r_div_out;
  assign fall_toggle = w_hit && r_div_out;
  assign div_out     = r_div_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div_out <= 1'b0;
    end else if (!run) begin
      r_cnt     <= '0;
      r_div_out <= 1'b0;
    end else if (w_hit) begin
      r_cnt     <= '0;
      r_div_out <= ~r_div_out;
    end else begin
      r_cnt     <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Start/stop and ratio-change sequencer for the divided clock; changes land only on falling toggles.
// Optional tick counter under CLK_DIV_TICK_COUNT_EN; cfg_ready stays low while a ratio is pending.
module clk_div_sequencer
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  cfg_valid,
  input  logic [CNT_W-1:0]      cfg_div,
  output logic                  cfg_ready,
  output logic                  div_out,
  output logic                  tick,
  output logic [1:0]            state,
  output logic                  pend,
  output logic [TICK_CNT_W-1:0] tick_count
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_div_reg;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend;
  logic             r_tick;
  logic             w_run;
  logic             w_fall;
  logic             w_rise;
  logic             w_div_out;
  logic             w_xfer;
  logic             w_to_idle;

  assign w_xfer    = cfg_valid && !r_pend;
  assign cfg_ready = !r_pend;
  assign pend      = r_pend;
  assign div_out   = w_div_out;
  assign tick      = r_tick;
  assign state     = r_state;

  // A low phase with en dropped is abandoned at once; a high phase is always finished.
  assign w_run = (r_state == ST_STOP) || ((r_state == ST_RUN) && (en || w_div_out));

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .run         (w_run),
    .div_reg     (r_div_reg),
    .fall_toggle (w_fall),
    .rise_toggle (w_rise),
    .div_out     (w_div_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_to_idle   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          if (!w_div_out || w_fall) begin
            w_state_nxt = ST_IDLE;
            w_to_idle   = 1'b1;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_to_idle   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_rise;
    end
  end

  // Entering IDLE is also a boundary, so nothing is left pending with the divider parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_reg  <= DIV_INIT;
      r_pend_div <= '0;
      r_pend     <= 1'b0;
    end else if (w_xfer && ((r_state == ST_IDLE) || w_to_idle)) begin
      r_div_reg  <= cfg_div;
    end else if (r_pend && (w_fall || w_to_idle)) begin
      r_div_reg  <= r_pend_div;
      r_pend     <= 1'b0;
    end else if (w_xfer) begin
      r_pend_div <= cfg_div;
      r_pend     <= 1'b1;
    end
  end

`ifdef CLK_DIV_TICK_COUNT_EN
  localparam logic [TICK_CNT_W-1:0] TICK_ONE = TICK_CNT_W'(1);

  logic [TICK_CNT_W-1:0] r_tick_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_count <= '0;
    end else if (r_tick && (r_state != ST_IDLE)) begin
      r_tick_count <= r_tick_count + TICK_ONE;
    end
  end

  assign tick_count = r_tick_count;
`else
  assign tick_count = '0;
`endif

endmodule

// File: doc/clk_div_sequencer.md
Name: clk_div_sequencer

Overview:
Run-time controller for the design's divided-clock output. It sequences start and stop of a programmable divider and accepts new divide ratios over a valid/ready handshake. Ratio changes and stops happen only at period boundaries, so the divided output never shows a truncated or glitched phase. It sits between the top-level pin wrapper (config from ui_in/uio_in) and the uo_out pin that drives the divided clock.

Parameters:
CNT_W, 8, width of the divide-ratio and half-period counter.
DIV_DEFAULT, 2, ratio loaded at reset; must fit in CNT_W bits.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_div  input  CNT_W  ratio R; half-period = R+1 clk cycles
cfg_ready  output  1  ratio can be accepted this cycle
div_out  output  1  divided clock
tick  output  1  one-cycle pulse coincident with each div_out 0->1 edge
state  output  2  0=IDLE, 1=RUN, 2=STOP
pend  output  1  accepted ratio waiting for a boundary
tick_count  output  16  optional; see Optional Feature

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset). Reset takes effect at the next clk edge, including mid-operation.
- Reset values: state=IDLE, div_out=0, tick=0, cnt=0, div_reg=DIV_DEFAULT, pend=0, pend_div=0, tick_count=0.
- Registered outputs:
  - div_out, tick and state are registered.
  - cfg_ready is combinational: cfg_ready = ~pend.
  - A transfer occurs when cfg_valid & cfg_ready at a clk edge.
- IDLE:
  - cnt held at 0 and div_out held at 0.
  - An accepted cfg_div loads div_reg directly at that edge; pend stays 0.
  - en=1 -> RUN next cycle, with cnt=0 and div_out=0.
- RUN:
  - cnt increments each cycle.
  - When cnt==div_reg: cnt<=0 and div_out toggles.
  - tick=1 in the cycle div_out becomes 1.
  - Output period is 2*(div_reg+1) cycles; div_reg=0 gives clk/2.
- Ratio change in RUN or STOP:
  - An accepted ratio goes to pend_div and sets pend=1.
  - The new ratio is applied at the next falling toggle (div_out 1->0): div_reg<=pend_div, pend<=0.
  - A transfer accepted in the same cycle as a falling toggle is applied at the following falling toggle, not the current one.
- en=0 in RUN:
  - If div_out=0, go to IDLE next cycle, with cnt<=0.
  - If div_out=1, go to STOP.
- STOP:
  - Counting continues until the falling toggle, then IDLE.
  - A pending ratio is applied on that same toggle.
  - en returning to 1 in STOP is ignored until IDLE is reached; restart from IDLE on the next cycle if en is still 1.
- Boundaries:
  - div_reg=0 in STOP: the stop completes on the next cycle.
  - The ratio in cfg_div is never truncated: CNT_W bits map straight to div_reg.
  - cnt only compares for equality. It cannot exceed div_reg because div_reg changes only when cnt is reset to 0.

Optional Feature:
CLK_DIV_TICK_COUNT_EN:
- Defined: a 16-bit counter increments on each tick, wraps 0xFFFF->0x0000, and clears on reset. It holds its value in IDLE and is driven to tick_count.
- Undefined: no counter is synthesised and tick_count is tied to 0.

Decomposition:
- Package clk_div_pkg holds the state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2), default CNT_W=8, DIV_DEFAULT=2 and TICK_CNT_W=16.
- Sub-module clk_div_core holds cnt, div_out and the toggle/tick logic.
  - Inputs: run, div_reg.
  - Outputs: fall_toggle, rise_toggle.
- The top level holds the FSM, the handshake, pend_div and the optional counter.

Test Plan:
- Reset, then en=1 with DIV_DEFAULT=2 -> div_out toggles every 3 cycles (period 6), tick every 6 cycles, state=1.
- In IDLE, cfg_div=0 with valid, then en=1 -> div_out alternates every cycle, tick every 2 cycles, pend stays 0.
- RUN at R=2, cfg_div=5 accepted while div_out=0 -> pend=1 and cfg_ready=0; the current high phase is 3 cycles; after the next falling toggle both phases are 6 cycles and pend=0.
- RUN at R=3, en=0 one cycle after div_out rises -> state=STOP, the high phase completes its full 4 cycles, then state=IDLE with div_out=0; en=0 while div_out=0 -> IDLE next cycle.
- Config accepted in the same cycle as a falling toggle -> old ratio used for one more full period, new ratio applied at the next fall.
- reset pulsed in mid-RUN with pend=1 -> next cycle: div_out=0, state=0, pend=0, div_reg=2. With CLK_DIV_TICK_COUNT_EN: 10 ticks give tick_count=10, and reset returns it to 0.
